load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 32 +++
 rtl/load_store_unit.sv | 183 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signal bundle for load_store_unit.
// slave  : the load/store unit side.
// master : the requester plus word-addressed memory side.
interface load_store_unit_if;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RespValid;
    logic [31:0] RespData;
    logic        MisalignErr;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] MemReadData;

    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemReadData,
        output ReqReady, RespValid, RespData, MisalignErr,
               MemAddress, MemWriteData, MemWrite, MemRead
    );

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemReadData,
        input  ReqReady, RespValid, RespData, MisalignErr,
               MemAddress, MemWriteData, MemWrite, MemRead
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a word-addressed memory with a
// one-cycle registered read. Sub-word stores are read-modify-write.
// Optional macro LSU_MISALIGN_CHECK_EN: misaligned half/word requests are
// dropped and flagged on MisalignErr; otherwise they are forced aligned.
module load_store_unit #(
    parameter int unsigned MEM_AW = 10
) (
    input  logic              Clk,
    input  logic              Rst_n,
    load_store_unit_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, LDONE} state_t;

    state_t            state_q, state_d;
    logic [MEM_AW-1:0] word_q, word_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              write_q, write_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_data_q, resp_data_d;

    logic [1:0]        req_off;
    logic              req_misaligned;
    logic              req_ready;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [31:0]       load_ext;
    logic [31:0]       merged;
    logic              unused_addr;

    // Address bits above the memory range are discarded (wrap-around).
    assign unused_addr = ^bus.ReqAddr[31:MEM_AW+2];

`ifdef LSU_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign req_off        = bus.ReqAddr[1:0];
    assign req_misaligned = ((bus.ReqSize == 2'b01) && bus.ReqAddr[0]) ||
                            (bus.ReqSize[1] && (bus.ReqAddr[1:0] != 2'b00));
    assign bus.MisalignErr = misalign_q;
`else
    // Drop the low offset bits a half/word cannot use so it lands aligned.
    always_comb begin
        req_off = bus.ReqAddr[1:0];
        if (bus.ReqSize[1]) begin
            req_off = 2'b00;
        end else if (bus.ReqSize[0]) begin
            req_off[0] = 1'b0;
        end
    end
    assign req_misaligned  = 1'b0;
    assign bus.MisalignErr = 1'b0;
`endif

    assign req_ready = Rst_n && (state_q == IDLE);

    // Select the addressed lane of the read word and extend it.
    always_comb begin
        lane_byte = bus.MemReadData[7:0];
        case (off_q)
            2'd1:    lane_byte = bus.MemReadData[15:8];
            2'd2:    lane_byte = bus.MemReadData[23:16];
            2'd3:    lane_byte = bus.MemReadData[31:24];
            default: lane_byte = bus.MemReadData[7:0];
        endcase
        lane_half = off_q[1] ? bus.MemReadData[31:16] : bus.MemReadData[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & lane_byte[7]}}, lane_byte};
            2'b01:   load_ext = {{16{signed_q & lane_half[15]}}, lane_half};
            default: load_ext = bus.MemReadData;
        endcase
    end

    // Replace only the addressed lane(s) of the read word with store data.
    always_comb begin
        merged = bus.MemReadData;
        case (size_q)
            2'b00: begin
                case (off_q)
                    2'd1:    merged[15:8]  = wdata_q[7:0];
                    2'd2:    merged[23:16] = wdata_q[7:0];
                    2'd3:    merged[31:24] = wdata_q[7:0];
                    default: merged[7:0]   = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (off_q[1]) merged[31:16] = wdata_q[15:0];
                else          merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    // Next-state, request latching and load-response computation.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        off_d        = off_q;
        size_d       = size_q;
        signed_d     = signed_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
`ifdef LSU_MISALIGN_CHECK_EN
        misalign_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.ReqValid && req_ready) begin
                    word_d   = bus.ReqAddr[MEM_AW+1:2];
                    off_d    = req_off;
                    size_d   = bus.ReqSize;
                    signed_d = bus.ReqSigned;
                    write_d  = bus.ReqWrite;
                    wdata_d  = bus.ReqWData;
                    if (req_misaligned) begin
`ifdef LSU_MISALIGN_CHECK_EN
                        misalign_d = 1'b1;
`endif
                        state_d = IDLE;
                    end else if (bus.ReqWrite && bus.ReqSize[1]) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = write_q ? MERGE : LDONE;
            MERGE:   state_d = IDLE;
            WR:      state_d = IDLE;
            LDONE: begin
                resp_valid_d = 1'b1;
                resp_data_d  = load_ext;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            word_q       <= '0;
            off_q        <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            off_q        <= off_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    assign bus.ReqReady     = req_ready;
    assign bus.MemRead      = (state_q == RD);
    assign bus.MemWrite     = (state_q == MERGE) || (state_q == WR);
    assign bus.MemAddress   = {{(32-MEM_AW){1'b0}}, word_q};
    assign bus.MemWriteData = (state_q == MERGE) ? merged : wdata_q;
    assign bus.RespValid    = resp_valid_q;
    assign bus.RespData     = resp_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a 1024-word
// registered-read memory model.
module tb_load_store_unit;

    logic Clk;
    logic Rst_n;
    load_store_unit_if bus ();

    load_store_unit #(.MEM_AW(10)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [0:1023];
    int          checks;
    int          errors;
    logic [31:0] last_resp;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_maddr;
        logic [31:0] exp_val;
        int          exp_busy;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Word-addressed memory: write on the edge after MemWrite, registered read.
    always @(posedge Clk) begin
        if (bus.MemWrite) mem[bus.MemAddress[9:0]] <= bus.MemWriteData;
        bus.MemReadData <= mem[bus.MemAddress[9:0]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string n, input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ma,
                           input logic [31:0] ev, input int busy, input logic mis);
        vec_t v;
        v.name = n; v.wr = wr; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd;
        v.exp_maddr = ma; v.exp_val = ev; v.exp_busy = busy; v.exp_mis = mis;
        vecs.push_back(v);
    endtask

    // Issue one request (called #1 after a posedge) and observe five cycles.
    task automatic run_vec(input vec_t v);
        int          busy = 0, resp_n = 0, mis_n = 0, acc_n = 0, both = 0;
        int          resp_at = -1, mis_at = -1;
        logic [31:0] resp_d = '0, seen_addr = '0;
        chk({v.name, "_ready_before"}, 32'(bus.ReqReady), 32'd1);
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = v.wr;
        bus.ReqSize   = v.size;
        bus.ReqSigned = v.sgn;
        bus.ReqAddr   = v.addr;
        bus.ReqWData  = v.wdata;
        @(posedge Clk);
        #1;
        bus.ReqValid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                @(posedge Clk);
                #1;
            end
            if (!bus.ReqReady) busy++;
            if (bus.MemRead && bus.MemWrite) both++;
            if (bus.MemRead || bus.MemWrite) begin
                if (acc_n == 0) seen_addr = bus.MemAddress;
                acc_n++;
            end
            if (bus.RespValid) begin
                if (resp_n == 0) begin resp_at = c; resp_d = bus.RespData; end
                resp_n++;
            end
            if (bus.MisalignErr) begin
                if (mis_n == 0) mis_at = c;
                mis_n++;
            end
        end
        chk({v.name, "_busy"}, 32'(busy), 32'(v.exp_busy));
        chk({v.name, "_rd_and_wr"}, 32'(both), 32'd0);
        if (v.exp_mis) begin
            chk({v.name, "_mis_count"}, 32'(mis_n), 32'd1);
            chk({v.name, "_mis_cycle"}, 32'(mis_at), 32'd0);
            chk({v.name, "_mem_access"}, 32'(acc_n), 32'd0);
            chk({v.name, "_resp_count"}, 32'(resp_n), 32'd0);
        end else begin
            chk({v.name, "_mis_count"}, 32'(mis_n), 32'd0);
            chk({v.name, "_mem_addr"}, seen_addr, v.exp_maddr);
            if (v.wr) begin
                chk({v.name, "_resp_count"}, 32'(resp_n), 32'd0);
                chk({v.name, "_mem_word"}, mem[v.exp_maddr[9:0]], v.exp_val);
                chk({v.name, "_resp_hold"}, bus.RespData, last_resp);
            end else begin
                chk({v.name, "_resp_count"}, 32'(resp_n), 32'd1);
                chk({v.name, "_resp_cycle"}, 32'(resp_at), 32'd2);
                chk({v.name, "_resp_data"}, resp_d, v.exp_val);
                last_resp = v.exp_val;
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        last_resp = '0;
        for (int i = 0; i < 1024; i++) mem[i] <= '0;
        mem[0]   <= 32'h1122_3344;
        mem[1]   <= 32'h5566_7788;
        mem[992] <= 32'h8899_AABB;

        //        name    wr  size   sgn  addr           wdata          maddr   expected       busy mis
        add_vec("sw_993",  1, 2'b10, 0, 32'h0000_0F84, 32'd22,        32'd993,  32'd22,        1, 0);
        add_vec("lw_993",  0, 2'b10, 0, 32'h0000_0F84, 32'd0,         32'd993,  32'd22,        2, 0);
        add_vec("lb_f83",  0, 2'b00, 1, 32'h0000_0F83, 32'd0,         32'd992,  32'hFFFF_FF88, 2, 0);
        add_vec("lbu_f83", 0, 2'b00, 0, 32'h0000_0F83, 32'd0,         32'd992,  32'h0000_0088, 2, 0);
        add_vec("lh_f80",  0, 2'b01, 1, 32'h0000_0F80, 32'd0,         32'd992,  32'hFFFF_AABB, 2, 0);
        add_vec("lhu_f82", 0, 2'b01, 0, 32'h0000_0F82, 32'd0,         32'd992,  32'h0000_8899, 2, 0);
        add_vec("lb_f81",  0, 2'b00, 1, 32'h0000_0F81, 32'd0,         32'd992,  32'hFFFF_FFAA, 2, 0);
        add_vec("lbu_f80", 0, 2'b00, 0, 32'h0000_0F80, 32'd0,         32'd992,  32'h0000_00BB, 2, 0);
        add_vec("sb_1",    1, 2'b00, 0, 32'h0000_0001, 32'h0000_00FF, 32'd0,    32'h1122_FF44, 2, 0);
        add_vec("sh_2",    1, 2'b01, 0, 32'h0000_0002, 32'h1234_ABCD, 32'd0,    32'hABCD_FF44, 2, 0);
        add_vec("sb_3",    1, 2'b00, 1, 32'h0000_0003, 32'h0000_005A, 32'd0,    32'h5ACD_FF44, 2, 0);
        add_vec("sw_1ffc", 1, 2'b10, 0, 32'h0000_1FFC, 32'hDEAD_BEEF, 32'd1023, 32'hDEAD_BEEF, 1, 0);
        add_vec("sw_2000", 1, 2'b10, 0, 32'h0000_2000, 32'hCAFE_F00D, 32'd0,    32'hCAFE_F00D, 1, 0);
        add_vec("lbu_1",   0, 2'b00, 0, 32'h0000_0001, 32'd0,         32'd0,    32'h0000_00F0, 2, 0);
        add_vec("lb_3",    0, 2'b00, 1, 32'h0000_0003, 32'd0,         32'd0,    32'hFFFF_FFCA, 2, 0);
        add_vec("l11_1ffc",0, 2'b11, 0, 32'h0000_1FFC, 32'd0,         32'd1023, 32'hDEAD_BEEF, 2, 0);
        add_vec("lh_hiadr",0, 2'b01, 1, 32'hFFFF_0F84, 32'd0,         32'd993,  32'h0000_0016, 2, 0);
        add_vec("sh_6",    1, 2'b01, 0, 32'h0000_0006, 32'h0000_BEEF, 32'd1,    32'hBEEF_7788, 2, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        add_vec("lw_6",    0, 2'b10, 0, 32'h0000_0006, 32'd0,         32'd0,    32'd0,         0, 1);
        add_vec("lh_f83",  0, 2'b01, 1, 32'h0000_0F83, 32'd0,         32'd0,    32'd0,         0, 1);
        add_vec("sw_5",    1, 2'b10, 0, 32'h0000_0005, 32'h0102_0304, 32'd0,    32'd0,         0, 1);
`else
        add_vec("lw_6",    0, 2'b10, 0, 32'h0000_0006, 32'd0,         32'd1,    32'hBEEF_7788, 2, 0);
        add_vec("lh_f83",  0, 2'b01, 1, 32'h0000_0F83, 32'd0,         32'd992,  32'hFFFF_8899, 2, 0);
        add_vec("sw_5",    1, 2'b10, 0, 32'h0000_0005, 32'h0102_0304, 32'd1,    32'h0102_0304, 1, 0);
`endif

        // Reset state, asserted asynchronously away from any clock edge.
        Rst_n         = 1'b1;
        bus.ReqValid  = 1'b0;
        bus.ReqWrite  = 1'b0;
        bus.ReqSize   = 2'b00;
        bus.ReqSigned = 1'b0;
        bus.ReqAddr   = '0;
        bus.ReqWData  = '0;
        #1 Rst_n = 1'b0;
        #2;
        chk("rst_ready",     32'(bus.ReqReady),    32'd0);
        chk("rst_respvalid", 32'(bus.RespValid),   32'd0);
        chk("rst_respdata",  bus.RespData,         32'd0);
        chk("rst_misalign",  32'(bus.MisalignErr), 32'd0);
        chk("rst_memwrite",  32'(bus.MemWrite),    32'd0);
        chk("rst_memread",   32'(bus.MemRead),     32'd0);
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("post_rst_ready", 32'(bus.ReqReady), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during the MERGE cycle of a half store must suppress the write.
        chk("merge_rst_ready", 32'(bus.ReqReady), 32'd1);
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = 1'b1;
        bus.ReqSize   = 2'b01;
        bus.ReqSigned = 1'b0;
        bus.ReqAddr   = 32'h0000_0002;
        bus.ReqWData  = 32'h0000_7777;
        @(posedge Clk);
        #1;
        bus.ReqValid = 1'b0;
        chk("merge_rst_rd", 32'(bus.MemRead), 32'd1);
        @(posedge Clk);
        #1;
        chk("merge_rst_wr_before", 32'(bus.MemWrite), 32'd1);
        Rst_n = 1'b0;
        #1;
        chk("merge_rst_wr_after",  32'(bus.MemWrite), 32'd0);
        chk("merge_rst_ready_low", 32'(bus.ReqReady), 32'd0);
        chk("merge_rst_respdata",  bus.RespData,      32'd0);
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        last_resp = '0;
        chk("merge_rst_ready_after", 32'(bus.ReqReady), 32'd1);
        chk("merge_rst_mem0",        mem[0],            32'hCAFE_F00D);

        // Normal operation resumes after the aborted transaction.
        begin
            vec_t v;
            v.name = "lw_0_after_rst"; v.wr = 1'b0; v.size = 2'b10; v.sgn = 1'b0;
            v.addr = 32'h0; v.wdata = 32'h0; v.exp_maddr = 32'd0;
            v.exp_val = 32'hCAFE_F00D; v.exp_busy = 2; v.exp_mis = 1'b0;
            run_vec(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
